// File: rtl/mips_pkg.sv
// mips_pkg: controller state enum plus opcode, funct, aluop and alucontrol encodings
package mips_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_SLT = 3'b111;
endpackage

// File: rtl/aludec.sv
// aludec: alucontrol[2:0] from aluop[1:0] and funct[5:0]; unknown funct falls back to add
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  always_comb
    alucontrol = aluop == ALUOP_ADD ? AC_ADD :
                 aluop == ALUOP_SUB ? AC_SUB :
                 funct == F_ADD     ? AC_ADD :
                 funct == F_SUB     ? AC_SUB :
                 funct == F_AND     ? AC_AND :
                 funct == F_OR      ? AC_OR  :
                 funct == F_SLT     ? AC_SLT : AC_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS FSM; in clk/reset/op/funct/zero/mem_ready, out datapath enables+selects, pcen, alucontrol, instr_done (all 0 in reset)
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       instr_done
);
  state_t state, next;
  logic pcwrite, branch;
  logic [1:0] aluop;
  logic [2:0] ac;
  aludec u_aludec (.aluop(aluop), .funct(funct), .alucontrol(ac));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else       state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:   next = mem_ready ? DECODE : FETCH;
      DECODE:  next = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_RTYPE ? EXECUTE :
                      op == OP_BEQ   ? BRANCH  :
                      op == OP_ADDI  ? ADDIEX  :
                      op == OP_J     ? JUMP    : FETCH;
      MEMADR:  next = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   next = mem_ready ? MEMWB : MEMRD;
      MEMWR:   next = mem_ready ? FETCH : MEMWR;
      EXECUTE: next = ALUWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    if (!reset)
      case (state)
        FETCH:   begin alusrcb = 2'b01; irwrite = mem_ready; pcwrite = mem_ready; end
        DECODE:  alusrcb = 2'b11;
        MEMADR, ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
        MEMRD:   iord = 1'b1;
        MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
        MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
        EXECUTE: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
        ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; end
        BRANCH:  begin alusrca = 1'b1; aluop = ALUOP_SUB; branch = 1'b1; pcsrc = 2'b01; end
        ADDIWB:  regwrite = 1'b1;
        JUMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
        default: ;
      endcase
    pcen       = pcwrite | (branch & zero);
    instr_done = !reset && state != FETCH && next == FETCH;
    alucontrol = reset ? 3'b000 : ac;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction cycle-list model checks of the multicycle controller
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic iord, memwrite, irwrite, regwrite, memtoreg, regdst, alusrca, pcen, instr_done;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  int checks = 0, errors = 0;
  typedef struct {logic mr; logic [12:0] e; logic [2:0] ac; logic chk;} cyc_t;
  cyc_t q[$];
  wire [12:0] obs = {iord, memwrite, irwrite, regwrite, memtoreg, regdst, alusrca, alusrcb, pcsrc, pcen, instr_done};
  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .memtoreg(memtoreg),
    .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .instr_done(instr_done)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] mk(int io, int mw, int irw, int rw, int m2r, int rd, int asa, int asb, int pcs, int pe, int dn);
    return {1'(io), 1'(mw), 1'(irw), 1'(rw), 1'(m2r), 1'(rd), 1'(asa), 2'(asb), 2'(pcs), 1'(pe), 1'(dn)};
  endfunction
  function automatic logic [2:0] alu_ref(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic bit known(logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction
  task automatic push(int mr, logic [12:0] e, logic [2:0] ac, int chk);
    cyc_t c;
    c.mr = 1'(mr); c.e = e; c.ac = ac; c.chk = 1'(chk);
    q.push_back(c);
  endtask
  task automatic build(logic [5:0] o, logic [5:0] f, logic z, int wf, int wm);
    int r;
    r = int'($urandom_range(0, 1));
    repeat (wf) push(0, mk(0,0,0,0,0,0,0,1,0,0,0), 3'b010, 1);
    push(1, mk(0,0,1,0,0,0,0,1,0,1,0), 3'b010, 1);
    push(r, mk(0,0,0,0,0,0,0,3,0,0,known(o) ? 0 : 1), 3'b010, 1);
    case (o)
      6'b100011: begin
        push(r, mk(0,0,0,0,0,0,1,2,0,0,0), 3'b010, 1);
        repeat (wm) push(0, mk(1,0,0,0,0,0,0,0,0,0,0), 3'b000, 0);
        push(1, mk(1,0,0,0,0,0,0,0,0,0,0), 3'b000, 0);
        push(r, mk(0,0,0,1,1,0,0,0,0,0,1), 3'b000, 0);
      end
      6'b101011: begin
        push(r, mk(0,0,0,0,0,0,1,2,0,0,0), 3'b010, 1);
        repeat (wm) push(0, mk(1,1,0,0,0,0,0,0,0,0,0), 3'b000, 0);
        push(1, mk(1,1,0,0,0,0,0,0,0,0,1), 3'b000, 0);
      end
      6'b000000: begin
        push(r, mk(0,0,0,0,0,0,1,0,0,0,0), alu_ref(f), 1);
        push(r, mk(0,0,0,1,0,1,0,0,0,0,1), 3'b000, 0);
      end
      6'b000100: push(r, mk(0,0,0,0,0,0,1,0,1,int'(z),1), 3'b110, 1);
      6'b001000: begin
        push(r, mk(0,0,0,0,0,0,1,2,0,0,0), 3'b010, 1);
        push(r, mk(0,0,0,1,0,0,0,0,0,0,1), 3'b000, 0);
      end
      6'b000010: push(r, mk(0,0,0,0,0,0,0,0,2,1,1), 3'b000, 0);
      default: ;
    endcase
  endtask
  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; op = 6'b100011;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 13'b0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", obs, 13'b0); end
    checks++;
    if (alucontrol !== 3'b000) begin errors++; $display("FAIL reset_alu: got %b expected 000", alucontrol); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic test_directed;
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000100, 6'b000100, 6'b000000, 6'b111111};
    logic [5:0] fns [6] = '{6'b0, 6'b0, 6'b0, 6'b0, 6'b101010, 6'b0};
    logic zs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int wms [6] = '{0, 3, 0, 0, 0, 0};
    for (int s = 0; s < 6; s++) begin
      op = ops[s]; funct = fns[s]; zero = zs[s];
      build(ops[s], fns[s], zs[s], 0, wms[s]);
      for (int k = 0; q.size() > 0; k++) begin
        cyc_t c;
        c = q.pop_front();
        mem_ready = c.mr;
        @(negedge clk);
        checks++;
        if (obs !== c.e) begin errors++; $display("FAIL directed%0d cycle %0d ctl: got %b expected %b", s, k, obs, c.e); end
        if (c.chk) begin
          checks++;
          if (alucontrol !== c.ac) begin errors++; $display("FAIL directed%0d cycle %0d alu: got %b expected %b", s, k, alucontrol, c.ac); end
        end
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic test_random;
    logic [5:0] kops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] kfns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 80; n++) begin
      logic [5:0] o, f;
      int sel;
      sel = int'($urandom_range(0, 6));
      if (sel < 6) o = kops[sel];
      else begin
        o = 6'($urandom);
        while (known(o)) o = 6'($urandom);
      end
      sel = int'($urandom_range(0, 5));
      f = sel < 5 ? kfns[sel] : 6'($urandom);
      op = o; funct = f; zero = 1'($urandom_range(0, 1));
      build(o, f, zero, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      for (int k = 0; q.size() > 0; k++) begin
        cyc_t c;
        c = q.pop_front();
        mem_ready = c.mr;
        @(negedge clk);
        checks++;
        if (obs !== c.e) begin errors++; $display("FAIL random%0d op %b cycle %0d ctl: got %b expected %b", n, o, k, obs, c.e); end
        if (c.chk) begin
          checks++;
          if (alucontrol !== c.ac) begin errors++; $display("FAIL random%0d op %b cycle %0d alu: got %b expected %b", n, o, k, alucontrol, c.ac); end
        end
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic test_reset_mid;
    op = 6'b101011; funct = '0; zero = 1'b0;
    build(op, funct, zero, 0, 5);
    for (int k = 0; k < 4; k++) begin
      cyc_t c;
      c = q.pop_front();
      mem_ready = c.mr;
      @(negedge clk);
      checks++;
      if (obs !== c.e) begin errors++; $display("FAIL reset_mid cycle %0d ctl: got %b expected %b", k, obs, c.e); end
      @(posedge clk);
      #1;
    end
    q.delete();
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 13'b0) begin errors++; $display("FAIL reset_mid_abort: got %b expected %b", obs, 13'b0); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== mk(0,0,1,0,0,0,0,1,0,1,0)) begin errors++; $display("FAIL reset_mid_fetch: got %b expected %b", obs, mk(0,0,1,0,0,0,0,1,0,1,0)); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (obs !== mk(0,0,0,0,0,0,0,3,0,0,0)) begin errors++; $display("FAIL reset_mid_decode: got %b expected %b", obs, mk(0,0,0,0,0,0,0,3,0,0,0)); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
